// File: rtl/otter_decode_stage.sv
// OTTER RV32I decode stage: IF/ID pipeline register, immediate decode, redirect
// targets, branch resolution and PC-source select, plus a one-bubble squash after redirects.
module otter_decode_stage #(
  parameter logic [31:0] NOP = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IR,
  input  logic [31:0] IR_PC,
  input  logic        IR_VALID,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic [31:0] RS1_DATA,
  input  logic [31:0] RS2_DATA,
  output logic [31:0] ID_IR,
  output logic [31:0] ID_PC,
  output logic        ID_VALID,
  output logic [4:0]  RS1_ADDR,
  output logic [4:0]  RS2_ADDR,
  output logic [4:0]  RD_ADDR,
  output logic [31:0] IMM,
  output logic [31:0] JAL,
  output logic [31:0] BRANCH,
  output logic [31:0] JALR,
  output logic [1:0]  PC_SEL,
  output logic        REDIRECT
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] id_ir_q;
  logic [31:0] id_pc_q;
  logic        id_valid_q;
  logic        squash_q;

  // Squash is armed only by a redirect that actually reaches fetch this edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      id_ir_q    <= NOP;
      id_pc_q    <= 32'h0;
      id_valid_q <= 1'b0;
      squash_q   <= 1'b0;
    end else if (FLUSH) begin
      id_ir_q    <= NOP;
      id_valid_q <= 1'b0;
      squash_q   <= 1'b0;
    end else if (!STALL) begin
      if (squash_q) begin
        id_ir_q    <= NOP;
        id_valid_q <= 1'b0;
        squash_q   <= 1'b0;
      end else begin
        id_ir_q    <= IR_VALID ? IR : NOP;
        id_pc_q    <= IR_PC;
        id_valid_q <= IR_VALID;
        squash_q   <= REDIRECT;
      end
    end
  end

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic        br_taken;

  assign opcode = id_ir_q[6:0];
  assign funct3 = id_ir_q[14:12];

  assign i_imm = {{20{id_ir_q[31]}}, id_ir_q[31:20]};
  assign s_imm = {{20{id_ir_q[31]}}, id_ir_q[31:25], id_ir_q[11:7]};
  assign b_imm = {{19{id_ir_q[31]}}, id_ir_q[31], id_ir_q[7], id_ir_q[30:25],
                  id_ir_q[11:8], 1'b0};
  assign u_imm = {id_ir_q[31:12], 12'h000};
  assign j_imm = {{11{id_ir_q[31]}}, id_ir_q[31], id_ir_q[19:12], id_ir_q[20],
                  id_ir_q[30:21], 1'b0};

  always_comb begin
    IMM = 32'h0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: IMM = i_imm;
      OP_STORE:                            IMM = s_imm;
      OP_BRANCH:                           IMM = b_imm;
      OP_LUI, OP_AUIPC:                    IMM = u_imm;
      OP_JAL:                              IMM = j_imm;
      default:                             IMM = 32'h0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = (RS1_DATA == RS2_DATA);
      3'b001:  br_taken = (RS1_DATA != RS2_DATA);
      3'b100:  br_taken = ($signed(RS1_DATA) <  $signed(RS2_DATA));
      3'b101:  br_taken = ($signed(RS1_DATA) >= $signed(RS2_DATA));
      3'b110:  br_taken = (RS1_DATA <  RS2_DATA);
      3'b111:  br_taken = (RS1_DATA >= RS2_DATA);
      default: br_taken = 1'b0;
    endcase
  end

  // A stalled or bubble instruction never steers fetch; it re-evaluates once released.
  always_comb begin
    PC_SEL = 2'd0;
    if (id_valid_q && !STALL) begin
      case (opcode)
        OP_JAL:    PC_SEL = 2'd3;
        OP_JALR:   PC_SEL = 2'd1;
        OP_BRANCH: PC_SEL = br_taken ? 2'd2 : 2'd0;
        default:   PC_SEL = 2'd0;
      endcase
    end
  end

  assign REDIRECT = (PC_SEL != 2'd0);
  assign JAL      = id_pc_q + j_imm;
  assign BRANCH   = id_pc_q + b_imm;
  assign JALR     = (RS1_DATA + i_imm) & 32'hFFFF_FFFE;

  assign ID_IR    = id_ir_q;
  assign ID_PC    = id_pc_q;
  assign ID_VALID = id_valid_q;
  assign RS1_ADDR = id_ir_q[19:15];
  assign RS2_ADDR = id_ir_q[24:20];
  assign RD_ADDR  = id_ir_q[11:7];

endmodule

// File: tb/tb_otter_decode_stage.sv
// Directed bench for otter_decode_stage: vector table for decode/targets/branches,
// hand sequences for squash, stall, flush and asynchronous reset.
module tb_otter_decode_stage;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I_JAL = 32'h020000EF;
  localparam logic [31:0] I_BEQ = 32'hFE208CE3;
  localparam logic [31:0] I_ADD = 32'h00000033;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IR, IR_PC, RS1_DATA, RS2_DATA;
  logic        IR_VALID, STALL, FLUSH;
  logic [31:0] ID_IR, ID_PC, IMM, JAL, BRANCH, JALR;
  logic        ID_VALID, REDIRECT;
  logic [4:0]  RS1_ADDR, RS2_ADDR, RD_ADDR;
  logic [1:0]  PC_SEL;

  int checks = 0;
  int failures = 0;

  otter_decode_stage #(.NOP(NOP)) dut (
    .CLK(CLK), .RESET(RESET), .IR(IR), .IR_PC(IR_PC), .IR_VALID(IR_VALID),
    .STALL(STALL), .FLUSH(FLUSH), .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
    .ID_IR(ID_IR), .ID_PC(ID_PC), .ID_VALID(ID_VALID),
    .RS1_ADDR(RS1_ADDR), .RS2_ADDR(RS2_ADDR), .RD_ADDR(RD_ADDR),
    .IMM(IMM), .JAL(JAL), .BRANCH(BRANCH), .JALR(JALR),
    .PC_SEL(PC_SEL), .REDIRECT(REDIRECT)
  );

  always #5 CLK = ~CLK;

  // tk selects which target to check: 0 none, 1 JAL, 2 BRANCH, 3 JALR
  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [1:0]  sel;
    logic [1:0]  tk;
    logic [31:0] tgt;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic v);
    IR = ir; IR_PC = pc; IR_VALID = v;
  endtask

  // Load a bubble, then let any armed squash drain, leaving the pipe clean.
  task automatic drain();
    drive(NOP, 32'h0, 1'b0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    vecs[0]  = '{I_JAL,        32'h100, 32'h0,        32'h0, 32'h20,       2'd3, 2'd1, 32'h120,      5'd1};
    vecs[1]  = '{I_BEQ,        32'h200, 32'd7,        32'd7, 32'hFFFFFFF8, 2'd2, 2'd2, 32'h1F8,      5'd25};
    vecs[2]  = '{I_BEQ,        32'h200, 32'd7,        32'd8, 32'hFFFFFFF8, 2'd0, 2'd2, 32'h1F8,      5'd25};
    vecs[3]  = '{32'h00508067, 32'h300, 32'h1000,     32'h0, 32'h5,        2'd1, 2'd3, 32'h1004,     5'd0};
    vecs[4]  = '{32'h0020C463, 32'h40,  32'hFFFFFFFF, 32'd1, 32'h8,        2'd2, 2'd2, 32'h48,       5'd8};
    vecs[5]  = '{32'h0020E463, 32'h40,  32'hFFFFFFFF, 32'd1, 32'h8,        2'd0, 2'd2, 32'h48,       5'd8};
    vecs[6]  = '{32'h0020D463, 32'h40,  32'hFFFFFFFF, 32'd1, 32'h8,        2'd0, 2'd0, 32'h0,        5'd8};
    vecs[7]  = '{32'h0020F463, 32'h40,  32'hFFFFFFFF, 32'd1, 32'h8,        2'd2, 2'd2, 32'h48,       5'd8};
    vecs[8]  = '{32'h00209463, 32'h40,  32'd3,        32'd3, 32'h8,        2'd0, 2'd0, 32'h0,        5'd8};
    vecs[9]  = '{32'h00209463, 32'h40,  32'd3,        32'd4, 32'h8,        2'd2, 2'd2, 32'h48,       5'd8};
    vecs[10] = '{32'h0020A463, 32'h40,  32'd3,        32'd4, 32'h8,        2'd0, 2'd0, 32'h0,        5'd8};
    vecs[11] = '{I_BEQ,        32'h0,   32'd5,        32'd5, 32'hFFFFFFF8, 2'd2, 2'd2, 32'hFFFFFFF8, 5'd25};
    vecs[12] = '{32'h0020A623, 32'h50,  32'h0,        32'h0, 32'd12,       2'd0, 2'd0, 32'h0,        5'd12};
    vecs[13] = '{32'hFE20AE23, 32'h50,  32'h0,        32'h0, 32'hFFFFFFFC, 2'd0, 2'd0, 32'h0,        5'd28};
    vecs[14] = '{32'h123452B7, 32'h60,  32'h0,        32'h0, 32'h12345000, 2'd0, 2'd0, 32'h0,        5'd5};
    vecs[15] = '{32'hFFF00093, 32'h60,  32'h10,       32'h0, 32'hFFFFFFFF, 2'd0, 2'd3, 32'hE,        5'd1};
    vecs[16] = '{I_ADD,        32'h60,  32'h0,        32'h0, 32'h0,        2'd0, 2'd0, 32'h0,        5'd0};
    vecs[17] = '{32'h00001097, 32'h70,  32'h0,        32'h0, 32'h1000,     2'd0, 2'd0, 32'h0,        5'd1};

    RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
    RS1_DATA = 32'h0; RS2_DATA = 32'h0;
    drive(I_ADD, 32'h0, 1'b1);
    repeat (2) @(negedge CLK);
    chk("reset_id_ir", ID_IR, NOP);
    chk("reset_id_pc", ID_PC, 32'h0);
    chk("reset_id_valid", {31'b0, ID_VALID}, 32'h0);
    chk("reset_pc_sel", {30'b0, PC_SEL}, 32'h0);
    RESET = 1'b0;
    drain();

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].ir, vecs[i].pc, 1'b1);
      RS1_DATA = vecs[i].rs1; RS2_DATA = vecs[i].rs2;
      @(negedge CLK);
      chk($sformatf("v%0d_id_ir", i), ID_IR, vecs[i].ir);
      chk($sformatf("v%0d_id_valid", i), {31'b0, ID_VALID}, 32'h1);
      chk($sformatf("v%0d_imm", i), IMM, vecs[i].imm);
      chk($sformatf("v%0d_rd", i), {27'b0, RD_ADDR}, {27'b0, vecs[i].rd});
      chk($sformatf("v%0d_pc_sel", i), {30'b0, PC_SEL}, {30'b0, vecs[i].sel});
      chk($sformatf("v%0d_redirect", i), {31'b0, REDIRECT}, {31'b0, vecs[i].sel != 2'd0});
      case (vecs[i].tk)
        2'd1: chk($sformatf("v%0d_jal", i), JAL, vecs[i].tgt);
        2'd2: chk($sformatf("v%0d_branch", i), BRANCH, vecs[i].tgt);
        2'd3: chk($sformatf("v%0d_jalr", i), JALR, vecs[i].tgt);
        default: ;
      endcase
      $display("vec %0d ir=%08h pc_sel=%0d imm=%08h", i, vecs[i].ir, PC_SEL, IMM);
      drain();
    end

    // Taken jal: the edge after the redirect is squashed even with a valid IR.
    drive(I_JAL, 32'h100, 1'b1);
    @(negedge CLK);
    chk("seq_jal_sel", {30'b0, PC_SEL}, 32'd3);
    drive(I_ADD, 32'h104, 1'b0);
    @(negedge CLK);
    chk("seq_jal_bubble1", {31'b0, ID_VALID}, 32'h0);
    drive(I_ADD, 32'h120, 1'b1);
    @(negedge CLK);
    chk("seq_squash_valid", {31'b0, ID_VALID}, 32'h0);
    chk("seq_squash_ir", ID_IR, NOP);
    @(negedge CLK);
    chk("seq_target_valid", {31'b0, ID_VALID}, 32'h1);
    chk("seq_target_pc", ID_PC, 32'h120);
    $display("seq jal squash done");
    drain();

    // Not-taken branch arms no squash: the next instruction loads directly.
    drive(I_BEQ, 32'h200, 1'b1);
    RS1_DATA = 32'd7; RS2_DATA = 32'd8;
    @(negedge CLK);
    chk("seq_nt_sel", {30'b0, PC_SEL}, 32'h0);
    drive(I_ADD, 32'h204, 1'b1);
    @(negedge CLK);
    chk("seq_nt_next_valid", {31'b0, ID_VALID}, 32'h1);
    chk("seq_nt_next_pc", ID_PC, 32'h204);
    $display("seq not-taken branch done");
    drain();

    // Stall holds a taken jal without redirecting; releasing it redirects.
    drive(I_JAL, 32'h100, 1'b1);
    @(negedge CLK);
    STALL = 1'b1;
    drive(I_ADD, 32'h104, 1'b1);
    #1;
    chk("seq_stall_sel", {30'b0, PC_SEL}, 32'h0);
    chk("seq_stall_redirect", {31'b0, REDIRECT}, 32'h0);
    @(negedge CLK);
    chk("seq_stall_hold_ir", ID_IR, I_JAL);
    chk("seq_stall_hold_pc", ID_PC, 32'h100);
    STALL = 1'b0;
    #1;
    chk("seq_unstall_sel", {30'b0, PC_SEL}, 32'd3);
    $display("seq stall done");
    drain();

    // Flush with a redirect loads a bubble and arms no squash.
    drive(I_JAL, 32'h100, 1'b1);
    @(negedge CLK);
    FLUSH = 1'b1;
    #1;
    chk("seq_flush_redirect", {31'b0, REDIRECT}, 32'h1);
    @(negedge CLK);
    FLUSH = 1'b0;
    chk("seq_flush_valid", {31'b0, ID_VALID}, 32'h0);
    chk("seq_flush_ir", ID_IR, NOP);
    drive(I_ADD, 32'h300, 1'b1);
    @(negedge CLK);
    chk("seq_after_flush_valid", {31'b0, ID_VALID}, 32'h1);
    chk("seq_after_flush_pc", ID_PC, 32'h300);
    $display("seq flush done");
    drain();

    // Asynchronous reset mid-cycle clears state before the next edge.
    drive(I_JAL, 32'h100, 1'b1);
    @(negedge CLK);
    chk("seq_pre_reset_valid", {31'b0, ID_VALID}, 32'h1);
    #2 RESET = 1'b1;
    #1;
    chk("seq_async_ir", ID_IR, NOP);
    chk("seq_async_valid", {31'b0, ID_VALID}, 32'h0);
    chk("seq_async_sel", {30'b0, PC_SEL}, 32'h0);
    chk("seq_async_redirect", {31'b0, REDIRECT}, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    $display("seq async reset done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
